// File: rtl/servive_clock_mon_pkg.sv
// Shared types and helpers for the servive clock monitor.
// Holds the monitor FSM states and the tolerance-window bound calculation.
package servive_clock_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam int FAULT_CNT_W = 8;

    // Lower window bound, clamped at zero when the tolerance exceeds the target.
    function automatic int win_lo(input int exp_half, input int tol);
        return (exp_half > tol) ? (exp_half - tol) : 0;
    endfunction

    function automatic int win_hi(input int exp_half, input int tol);
        return exp_half + tol;
    endfunction

endpackage

// File: rtl/servive_sync_edge.sv
// Two-flop synchronizer plus history flop.
// Reports the synchronized level and a one-cycle pulse on either edge.
module servive_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic edge_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic hist_r;

    // Synchronizer chain and one-cycle history of the synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    assign level      = sync2_r;
    assign edge_pulse = sync2_r ^ hist_r;

endmodule

// File: rtl/servive_clock_mon.sv
// Slow-clock monitor: measures edge-to-edge intervals of i_mon_clk in the i_clk
// domain and qualifies them against EXP_HALF +/- TOL to report lock and faults.
module servive_clock_mon
    import servive_clock_mon_pkg::*;
#(
    parameter int EXP_HALF = 1_562_500,
    parameter int TOL      = 15_625,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_mon_clk,
    input  logic                   i_clr_fault,
    output logic                   o_locked,
    output logic                   o_fault,
    output logic [CW-1:0]          o_period,
    output logic                   o_period_vld,
    output logic [FAULT_CNT_W-1:0] o_fault_cnt
);

    localparam logic [CW:0] WIN_LO_C   = (CW+1)'(win_lo(EXP_HALF, TOL));
    localparam logic [CW:0] WIN_HI_C   = (CW+1)'(win_hi(EXP_HALF, TOL));
    localparam logic [3:0]  LOCK_CNT_C = 4'(LOCK_CNT);

    logic                   unused_mon_level_s;
    logic                   edge_s;
    logic [CW-1:0]          cnt_r;
    logic [CW:0]            interval_s;
    logic [CW-1:0]          period_s;
    logic                   good_s;
    logic                   timeout_s;
    state_e                 state_r;
    logic [3:0]             good_cnt_r;
    logic                   locked_r;
    logic                   fault_r;
    logic [CW-1:0]          period_r;
    logic                   period_vld_r;
    logic [FAULT_CNT_W-1:0] fault_cnt_r;

    servive_sync_edge u_sync (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .din        (i_mon_clk),
        .level      (unused_mon_level_s),
        .edge_pulse (edge_s)
    );

    // Interval is one wider than the counter so the window compare never overflows;
    // the reported period saturates with the counter instead of wrapping to zero.
    assign interval_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};
    assign period_s   = (&cnt_r) ? cnt_r : interval_s[CW-1:0];
    assign good_s     = (interval_s >= WIN_LO_C) && (interval_s <= WIN_HI_C);
    assign timeout_s  = !edge_s && (interval_s > WIN_HI_C);

    // Edge-interval counter: restarts on every detected edge, saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (edge_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (!(&cnt_r)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Acquisition FSM with registered status and period outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            good_cnt_r   <= 4'd0;
            locked_r     <= 1'b0;
            fault_r      <= 1'b0;
            period_r     <= {CW{1'b0}};
            period_vld_r <= 1'b0;
            fault_cnt_r  <= {FAULT_CNT_W{1'b0}};
        end else begin
            period_vld_r <= 1'b0;
            if (i_clr_fault) begin
                // A coincident edge is deliberately dropped: acquisition restarts from IDLE.
                state_r    <= IDLE;
                good_cnt_r <= 4'd0;
                locked_r   <= 1'b0;
                fault_r    <= 1'b0;
            end else begin
                if (edge_s && (state_r != IDLE)) begin
                    period_r     <= period_s;
                    period_vld_r <= 1'b1;
                end
                case (state_r)
                    IDLE: begin
                        if (edge_s) begin
                            state_r    <= TRACK;
                            good_cnt_r <= 4'd0;
                        end
                    end
                    TRACK: begin
                        if (edge_s) begin
                            if (!good_s) begin
                                good_cnt_r <= 4'd0;
                            end else if ((good_cnt_r + 4'd1) == LOCK_CNT_C) begin
                                state_r    <= LOCKED;
                                locked_r   <= 1'b1;
                                good_cnt_r <= 4'd0;
                            end else begin
                                good_cnt_r <= good_cnt_r + 4'd1;
                            end
                        end else if (timeout_s) begin
                            state_r    <= IDLE;
                            good_cnt_r <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if ((edge_s && !good_s) || timeout_s) begin
                            state_r  <= FAULT;
                            locked_r <= 1'b0;
                            fault_r  <= 1'b1;
                            if (fault_cnt_r != {FAULT_CNT_W{1'b1}}) begin
                                fault_cnt_r <= fault_cnt_r + {{(FAULT_CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    FAULT: begin
                        state_r <= FAULT;
                    end
                    default: begin
                        state_r    <= IDLE;
                        good_cnt_r <= 4'd0;
                        locked_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_locked     = locked_r;
    assign o_fault      = fault_r;
    assign o_period     = period_r;
    assign o_period_vld = period_vld_r;
    assign o_fault_cnt  = fault_cnt_r;

endmodule

// File: tb/tb_servive_clock_mon.sv
// Directed, table-driven bench for servive_clock_mon with EXP_HALF=100, TOL=5,
// LOCK_CNT=4, CW=8; inputs change and outputs are sampled on the falling edge.
module tb_servive_clock_mon;

    logic       clk_s = 1'b0;
    logic       rst_n_s;
    logic       mon_s;
    logic       clr_s;
    logic       locked_s;
    logic       fault_s;
    logic [7:0] period_s;
    logic       period_vld_s;
    logic [7:0] fault_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   gap;
        logic vld;
        int   period;
        logic locked;
    } vec_t;

    vec_t vecs[22];

    servive_clock_mon #(
        .EXP_HALF (100),
        .TOL      (5),
        .LOCK_CNT (4),
        .CW       (8)
    ) dut (
        .i_clk        (clk_s),
        .i_rst_n      (rst_n_s),
        .i_mon_clk    (mon_s),
        .i_clr_fault  (clr_s),
        .o_locked     (locked_s),
        .o_fault      (fault_s),
        .o_period     (period_s),
        .o_period_vld (period_vld_s),
        .o_fault_cnt  (fault_cnt_s)
    );

    // Reference clock, 10 time-unit period.
    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_s);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " locked"},     32'(locked_s),     32'd0);
        chk({tag, " fault"},      32'(fault_s),      32'd0);
        chk({tag, " period"},     32'(period_s),     32'd0);
        chk({tag, " period_vld"}, 32'(period_vld_s), 32'd0);
        chk({tag, " fault_cnt"},  32'(fault_cnt_s),  32'd0);
    endtask

    // Toggle i_mon_clk 'gap' cycles after the previous toggle, then check the edge result.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            repeat (vecs[i].gap - 4) cyc();
            mon_s = ~mon_s;
            repeat (3) cyc();
            chk($sformatf("vec%0d vld", i),    32'(period_vld_s), 32'(vecs[i].vld));
            chk($sformatf("vec%0d period", i), 32'(period_s),     32'(vecs[i].period));
            chk($sformatf("vec%0d locked", i), 32'(locked_s),     32'(vecs[i].locked));
            chk($sformatf("vec%0d fault", i),  32'(fault_s),      32'd0);
            cyc();
            chk($sformatf("vec%0d vld_pulse", i), 32'(period_vld_s), 32'd0);
        end
    endtask

    initial begin
        // Acquisition after reset: reference edge, then four good intervals to lock.
        vecs[0]  = '{10,  1'b0, 0,   1'b0};
        vecs[1]  = '{100, 1'b1, 100, 1'b0};
        vecs[2]  = '{100, 1'b1, 100, 1'b0};
        vecs[3]  = '{100, 1'b1, 100, 1'b0};
        vecs[4]  = '{100, 1'b1, 100, 1'b1};
        // Re-acquisition after clear: bad 94 and 106 restart the good count.
        vecs[5]  = '{100, 1'b0, 255, 1'b0};
        vecs[6]  = '{100, 1'b1, 100, 1'b0};
        vecs[7]  = '{100, 1'b1, 100, 1'b0};
        vecs[8]  = '{94,  1'b1, 94,  1'b0};
        vecs[9]  = '{95,  1'b1, 95,  1'b0};
        vecs[10] = '{105, 1'b1, 105, 1'b0};
        vecs[11] = '{100, 1'b1, 100, 1'b0};
        vecs[12] = '{106, 1'b1, 106, 1'b0};
        vecs[13] = '{100, 1'b1, 100, 1'b0};
        vecs[14] = '{100, 1'b1, 100, 1'b0};
        vecs[15] = '{100, 1'b1, 100, 1'b0};
        vecs[16] = '{100, 1'b1, 100, 1'b1};
        // Re-acquisition after a mid-lock reset.
        vecs[17] = '{10,  1'b0, 0,   1'b0};
        vecs[18] = '{100, 1'b1, 100, 1'b0};
        vecs[19] = '{100, 1'b1, 100, 1'b0};
        vecs[20] = '{100, 1'b1, 100, 1'b0};
        vecs[21] = '{100, 1'b1, 100, 1'b1};

        rst_n_s = 1'b0;
        mon_s   = 1'b0;
        clr_s   = 1'b0;
        repeat (3) cyc();
        chk_zero("reset");
        rst_n_s = 1'b1;

        run_vecs(0, 4);

        // Stop toggling once locked: timeout fires when cnt+1 passes 105.
        repeat (104) cyc();
        chk("pre_timeout fault",  32'(fault_s),  32'd0);
        chk("pre_timeout locked", 32'(locked_s), 32'd1);
        cyc();
        chk("timeout fault",     32'(fault_s),     32'd1);
        chk("timeout locked",    32'(locked_s),    32'd0);
        chk("timeout fault_cnt", 32'(fault_cnt_s), 32'd1);

        // Long static input in FAULT: measured interval saturates at 255.
        repeat (200) cyc();
        mon_s = ~mon_s;
        repeat (3) cyc();
        chk("sat vld",       32'(period_vld_s), 32'd1);
        chk("sat period",    32'(period_s),     32'd255);
        chk("sat fault",     32'(fault_s),      32'd1);
        chk("sat fault_cnt", 32'(fault_cnt_s),  32'd1);
        cyc();

        // Clear coincident with an edge: fault drops, the edge is not a reference.
        repeat (96) cyc();
        mon_s = ~mon_s;
        repeat (2) cyc();
        clr_s = 1'b1;
        cyc();
        clr_s = 1'b0;
        chk("clr fault",     32'(fault_s),      32'd0);
        chk("clr locked",    32'(locked_s),     32'd0);
        chk("clr vld",       32'(period_vld_s), 32'd0);
        chk("clr fault_cnt", 32'(fault_cnt_s),  32'd1);
        cyc();

        run_vecs(5, 16);
        chk("relock fault_cnt", 32'(fault_cnt_s), 32'd1);

        // Asynchronous reset while locked.
        repeat (20) cyc();
        #2;
        rst_n_s = 1'b0;
        #1;
        chk_zero("async_reset");
        mon_s = 1'b0;
        repeat (3) cyc();
        rst_n_s = 1'b1;

        run_vecs(17, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servive_clock_mon.md
Name: servive_clock_mon

Overview:
Receive-side companion to the servive slow-clock divider. It samples the divided clock, together with any other slow toggling signal, in the fast reference clock domain and measures the interval between edges. It then qualifies that interval against an expected half-period and reports lock, loss-of-lock and measured period. It sits beside the clock generator in the servive top level and drives a status LED and debug registers.

Parameters:
EXP_HALF, 1_562_500, expected half-period of the monitored clock, in i_clk cycles
TOL, 15_625, allowed absolute deviation from EXP_HALF, in i_clk cycles
LOCK_CNT, 4, consecutive in-tolerance intervals required to declare lock (1..15)
CW, 24, interval counter width; must hold EXP_HALF+TOL+1

Ports:
i_clk  in  1  fast reference clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_mon_clk  in  1  monitored slow clock, asynchronous to i_clk
i_clr_fault  in  1  one-cycle pulse that clears the sticky fault and restarts acquisition
o_locked  out  1  high while in LOCKED
o_fault  out  1  sticky loss-of-lock flag
o_period  out  CW  last measured edge-to-edge interval
o_period_vld  out  1  one-cycle strobe when o_period updates
o_fault_cnt  out  8  saturating count of LOCKED->FAULT transitions

Behaviour:
- Reset: all flops clear asynchronously. State=IDLE. o_locked=0, o_fault=0, o_period=0, o_period_vld=0, o_fault_cnt=0. Synchronizer flops=0.
- Input path: 2-flop synchronizer, then 1 history flop. edge = sync XOR hist (either polarity). Edge is asserted 2-3 i_clk cycles after the i_mon_clk transition.
- Counter cnt:
  - Clears to 0 on an edge cycle; otherwise increments.
  - Saturates at all-ones and never wraps.
  - interval = cnt+1 at the edge, i.e. the number of i_clk cycles between successive detected edges. A divider toggling every N cycles yields interval=N.
- good = (interval >= EXP_HALF-TOL) && (interval <= EXP_HALF+TOL). Compute in CW+1 bits; clamp the low bound at 0.
- timeout = (cnt+1 > EXP_HALF+TOL) with no edge that cycle. It is evaluated every cycle.
- Period output: on every edge except an edge taken in IDLE, o_period<=interval and o_period_vld=1 for exactly one cycle.
- State machine:
  - IDLE: waiting for a reference edge. Edge -> TRACK with good_cnt=0. No measurement and no timeout in IDLE.
  - TRACK, on edge:
    - good: good_cnt+1. Reaching LOCK_CNT -> LOCKED, with o_locked high the next cycle.
    - bad: good_cnt=0, stay in TRACK.
  - TRACK, on timeout: -> IDLE.
  - LOCKED: a bad edge interval or a timeout -> FAULT. Set o_fault=1, increment o_fault_cnt (saturate at 255), drop o_locked.
  - FAULT: holds until i_clr_fault. Edges still update o_period and o_period_vld.
- i_clr_fault:
  - In any state: -> IDLE, o_fault<=0, good_cnt<=0. o_fault_cnt is not cleared.
  - Has priority over an edge or timeout in the same cycle. The coincident edge still clears cnt but is not taken as a reference edge.
- Reset mid-operation: immediate return to reset values. The first post-reset edge is a reference only and produces no o_period_vld.
- All outputs are registered.

Decomposition:
- Package servive_clock_mon_pkg:
  - state enum {IDLE, TRACK, LOCKED, FAULT}
  - FAULT_CNT_W=8
  - helper function for the window bounds
- Sub-module servive_sync_edge: 2-flop synchronizer plus history flop, async active-low reset, outputs sync level and edge pulse. It is reused later for button/reset inputs.

Test Plan (EXP_HALF=100, TOL=5, LOCK_CNT=4, CW=8):
1. Toggle i_mon_clk every 100 cycles after reset:
   - first edge gives no o_period_vld;
   - the next 4 edges give o_period=100 each;
   - o_locked rises the cycle after the 5th edge;
   - o_fault stays 0.
2. Intervals 100,100,94,100 in TRACK: the 94 resets good_cnt, so lock needs 4 more good intervals. Boundary intervals 95 and 105 count as good; 106 counts as bad.
3. Once locked, stop toggling. Required response:
   - o_fault=1 and o_locked=0 on the cycle cnt+1 reaches 106;
   - o_fault_cnt=1.
4. In FAULT, pulse i_clr_fault in the same cycle as an edge:
   - o_fault=0 and state IDLE;
   - that edge is not used as a reference;
   - the following edge enters TRACK;
   - o_fault_cnt stays 1.
5. Hold i_mon_clk static for 300 cycles: cnt saturates at 255 with no wrap.
6. Assert i_rst_n=0 asynchronously mid-LOCKED: all outputs zero immediately, including o_fault_cnt, and reacquisition needs 1+4 edges.
